enable_arbiter: RTL and testbench

Two-requester round-robin scheduler for the shared 4-bit enable-gated output channel. Requesters A and B each present a request and a data word. The block grants the channel to one side at a time, drives the channel enable, and registers the granted side's data onto its gated output. The non-granted output and all outputs while idle read zero. It sits directly in front of the enable gate and replaces the free-running enable strobe with a sequenced, fair one.

---
 rtl/enable_arbiter.sv | 87 ++++++++
 tb/tb_enable_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/enable_arbiter.sv
// rtl/enable_arbiter.sv - two-requester round-robin scheduler driving a gated 4-bit channel
module enable_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             enab,
  output logic [WIDTH-1:0] y_a,
  output logic [WIDTH-1:0] y_b
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

  state_t          state;
  state_t          next_state;
  logic            last_b;
  logic [HW-1:0]   hold_cnt;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_a && req_b)
          next_state = last_b ? SERVE_A : SERVE_B;
        else if (req_a)
          next_state = SERVE_A;
        else if (req_b)
          next_state = SERVE_B;
        else
          next_state = IDLE;
      end
      SERVE_A: begin
        if (!req_a)
          next_state = req_b ? SERVE_B : IDLE;
        else if (req_b && hold_cnt == HOLD_LAST)
          next_state = SERVE_B;
      end
      SERVE_B: begin
        if (!req_b)
          next_state = req_a ? SERVE_A : IDLE;
        else if (req_a && hold_cnt == HOLD_LAST)
          next_state = SERVE_A;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so grant, enable and data move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      hold_cnt <= '0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      enab     <= 1'b0;
      y_a      <= '0;
      y_b      <= '0;
    end else begin
      state <= next_state;
      gnt_a <= (next_state == SERVE_A);
      gnt_b <= (next_state == SERVE_B);
      enab  <= (next_state != IDLE);
      y_a   <= (next_state == SERVE_A) ? data_a : '0;
      y_b   <= (next_state == SERVE_B) ? data_b : '0;
      if (next_state == IDLE) begin
        hold_cnt <= '0;
      end else if (next_state == state) begin
        hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + HW'(1);
      end else begin
        hold_cnt <= '0;
        last_b   <= (next_state == SERVE_B);
      end
    end
  end

endmodule

// File: tb/tb_enable_arbiter.sv
// tb/tb_enable_arbiter.sv - randomized and directed bench for enable_arbiter
module tb_enable_arbiter;
  localparam int W  = 4;
  localparam int MH = 4;
  localparam int VW = 3 + 2 * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_a = 1'b0, req_b = 1'b0;
  logic [W-1:0] data_a = '0, data_b = '0;
  logic         gnt_a, gnt_b, enab;
  logic [W-1:0] y_a, y_b;

  int total = 0;
  int bad   = 0;

  // Reference: owner 0=none 1=A 2=B, run = cycles the current grant has been visible.
  int           m_owner, m_last, m_run;
  logic [W-1:0] m_ya, m_yb;

  enable_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .enab(enab), .y_a(y_a), .y_b(y_b)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] obs_vec();
    return {gnt_a, gnt_b, enab, y_a, y_b};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_owner == 1, m_owner == 2, m_owner != 0, m_ya, m_yb};
  endfunction

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_run = 0; m_ya = '0; m_yb = '0;
  endtask

  task automatic model_update(input logic ra, input logic rb,
                              input logic [W-1:0] da, input logic [W-1:0] db);
    int nxt, other_side;
    logic mine, other;
    if (m_owner == 0) begin
      if (ra && rb)  nxt = (m_last == 1) ? 2 : 1;
      else if (ra)   nxt = 1;
      else if (rb)   nxt = 2;
      else           nxt = 0;
    end else begin
      mine       = (m_owner == 1) ? ra : rb;
      other      = (m_owner == 1) ? rb : ra;
      other_side = 3 - m_owner;
      if (!mine)                           nxt = other ? other_side : 0;
      else if (other && (m_run % MH) == 0) nxt = other_side;
      else                                 nxt = m_owner;
    end
    if (nxt == 0)            m_run = 0;
    else if (nxt == m_owner) m_run = m_run + 1;
    else begin m_run = 1; m_last = nxt; end
    m_owner = nxt;
    m_ya = (nxt == 1) ? da : '0;
    m_yb = (nxt == 2) ? db : '0;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_update(req_a, req_b, data_a, data_b);
    #1;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_a = 1'b1; req_b = 1'b1; data_a = 4'b1110; data_b = 4'b0011;
    rst_n = 1'b0; model_reset();
    #1;
    total++;
    if (obs_vec() !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", obs_vec());
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    total++;
    if ({gnt_a, gnt_b, enab, y_a, y_b} !== {3'b101, 4'b1110, 4'b0000}) begin
      bad++; $display("FAIL reset_first_grant got=%h want=%h", obs_vec(), {3'b101, 4'b1110, 4'b0000});
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_a = 1'b0; req_b = 1'b1; data_b = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if ({gnt_a, gnt_b, enab, y_a, y_b} !== {3'b011, 4'b0000, 4'b0101}) begin
        bad++; $display("FAIL single_b cyc=%0d got=%h want=%h", i, obs_vec(), {3'b011, 4'b0000, 4'b0101});
      end
    end
    req_b = 1'b0;
    step();
    total++;
    if (obs_vec() !== '0) begin
      bad++; $display("FAIL single_release got=%h want=0", obs_vec());
    end
  endtask

  task automatic test_contention();
    apply_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = 4'hA; data_b = 4'h5;
    for (int i = 0; i < 4 * MH + 3; i++) begin
      logic want_a;
      step();
      want_a = ((i / MH) % 2) == 0;
      total++;
      if (gnt_a !== want_a || gnt_b !== !want_a || enab !== 1'b1) begin
        bad++; $display("FAIL contention cyc=%0d got a=%b b=%b en=%b want a=%b", i, gnt_a, gnt_b, enab, want_a);
      end
    end
  endtask

  task automatic test_early_release();
    apply_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = 4'h1; data_b = 4'h2;
    step(); step();
    req_a = 1'b0;
    step();
    total++;
    if ({gnt_a, gnt_b} !== 2'b01) begin
      bad++; $display("FAIL early_switch got=%b%b want=01", gnt_a, gnt_b);
    end
    req_a = 1'b1;
    for (int i = 1; i < MH + 2; i++) begin
      step();
      total++;
      if (gnt_b !== (i < MH) || gnt_a !== (i >= MH) || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL early_hold cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    req_a = 1'b0; req_b = 1'b1; data_b = 4'h7;
    step(); step();
    total++;
    if (gnt_b !== 1'b1) begin
      bad++; $display("FAIL midreset_setup got gnt_b=%b want=1", gnt_b);
    end
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs_vec() !== '0) begin
      bad++; $display("FAIL midreset_async got=%h want=0", obs_vec());
    end
    req_a = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    step();
    total++;
    if ({gnt_a, gnt_b} !== 2'b10 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL midreset_first got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_data_tracking();
    logic [W-1:0] seq [3];
    seq[0] = 4'h3; seq[1] = 4'h9; seq[2] = 4'hF;
    apply_reset();
    req_a = 1'b1; req_b = 1'b0; data_b = 4'hC;
    for (int i = 0; i < 3; i++) begin
      data_a = seq[i];
      step();
      total++;
      if (y_a !== seq[i] || y_b !== 4'h0 || gnt_a !== 1'b1) begin
        bad++; $display("FAIL data_track cyc=%0d got y_a=%h y_b=%h want y_a=%h y_b=0", i, y_a, y_b, seq[i]);
      end
    end
    req_a = 1'b0;
    step();
    total++;
    if (y_a !== 4'h0) begin
      bad++; $display("FAIL data_drop got y_a=%h want=0", y_a);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      req_a  = ($urandom_range(0, 3) != 0);
      req_b  = ($urandom_range(0, 3) != 0);
      data_a = W'($urandom);
      data_b = W'($urandom);
      step();
      total++;
      if (obs_vec() !== exp_vec() || (gnt_a && gnt_b)) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_mid_reset();
    test_data_tracking();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
